// File: rtl/oam_dma_ctrl_if.sv
// ----------------------------------------------------------------------------
// oam_dma_ctrl_if
// Bus bundle for the sprite DMA engine. It groups the CPU-side register write,
// the CPU memory-map read port, the PPU register write port and the busy flag.
//
// Signals
//   cpu_addr     [15:0] CPU bus address
//   cpu_we              CPU write strobe
//   cpu_wdata    [7:0]  CPU write data (source page on a trigger write)
//   cpu_halt            1 = CPU must stall, DMA owns the bus
//   dma_addr     [15:0] read address into CPU memory space
//   dma_rd              read strobe to CPU memory map
//   dma_rdata    [7:0]  read data, valid the cycle after dma_rd
//   ppu_cs_n            PPU register chip select, active low
//   ppu_reg_addr [2:0]  PPU register index
//   ppu_we              PPU register write enable
//   ppu_wdata    [7:0]  PPU register write data
//   busy                transfer in progress
//
// Modports
//   master : the DMA controller
//   slave  : the surrounding system (CPU, memory map, PPU register block)
// ----------------------------------------------------------------------------
interface oam_dma_ctrl_if;
   logic [15:0] cpu_addr;
   logic        cpu_we;
   logic [7:0]  cpu_wdata;
   logic        cpu_halt;
   logic [15:0] dma_addr;
   logic        dma_rd;
   logic [7:0]  dma_rdata;
   logic        ppu_cs_n;
   logic [2:0]  ppu_reg_addr;
   logic        ppu_we;
   logic [7:0]  ppu_wdata;
   logic        busy;

   modport master (
      input  cpu_addr, cpu_we, cpu_wdata, dma_rdata,
      output cpu_halt, dma_addr, dma_rd, ppu_cs_n, ppu_reg_addr, ppu_we,
             ppu_wdata, busy
   );

   modport slave (
      output cpu_addr, cpu_we, cpu_wdata, dma_rdata,
      input  cpu_halt, dma_addr, dma_rd, ppu_cs_n, ppu_reg_addr, ppu_we,
             ppu_wdata, busy
   );
endinterface

// File: rtl/oam_dma_ctrl.sv
// ----------------------------------------------------------------------------
// oam_dma_ctrl
// Sprite DMA engine behind CPU register $4014. A CPU write of page P copies
// CPU addresses {P,00}..{P,FF} into OAM, one byte per read/write cycle pair,
// each byte delivered as an OAMDATA write to the PPU register block. The CPU
// is held off through cpu_halt for the whole transfer.
//
// Ports
//   clk    in  system clock, one CPU cycle per clock
//   reset  in  asynchronous, active-high
//   bus    oam_dma_ctrl_if.master (CPU write, memory read, PPU write, busy)
// ----------------------------------------------------------------------------
module oam_dma_ctrl #(
   parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
   parameter logic [2:0]  OAMDATA_IDX  = 3'd4,
   parameter int          XFER_LEN     = 256
) (
   input  logic           clk,
   input  logic           reset,
   oam_dma_ctrl_if.master bus
);

   localparam int IDX_W = $clog2(XFER_LEN);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(XFER_LEN - 1);

   typedef enum logic [2:0] {
      IDLE,
      HALT,
      DUMMY,
      ALIGN,
      READ,
      WRITE
   } state_t;

   state_t           state_reg;
   logic [IDX_W-1:0] idx_reg;
   logic [7:0]       page_reg;
   logic             par_reg;

   logic             halt_reg;
   logic             rd_reg;
   logic [15:0]      addr_reg;
   logic             cs_n_reg;
   logic             we_reg;
   logic             busy_reg;

   logic             trigger;
   logic [IDX_W-1:0] idx_inc;

   assign trigger = bus.cpu_we && (bus.cpu_addr == DMA_REG_ADDR);
   assign idx_inc = idx_reg + IDX_W'(1);

   // Outputs are registered alongside the state: each transition loads the
   // output values that belong to the state being entered.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
         idx_reg   <= '0;
         page_reg  <= '0;
         par_reg   <= 1'b0;
         halt_reg  <= 1'b0;
         rd_reg    <= 1'b0;
         addr_reg  <= '0;
         cs_n_reg  <= 1'b1;
         we_reg    <= 1'b0;
         busy_reg  <= 1'b0;
      end else begin
         par_reg  <= ~par_reg;
         rd_reg   <= 1'b0;
         addr_reg <= '0;
         cs_n_reg <= 1'b1;
         we_reg   <= 1'b0;

         case (state_reg)
            IDLE: begin
               if (trigger) begin
                  page_reg  <= bus.cpu_wdata;
                  idx_reg   <= '0;
                  state_reg <= HALT;
                  halt_reg  <= 1'b1;
                  busy_reg  <= 1'b1;
               end
            end

            HALT: state_reg <= DUMMY;

            // par_reg is the current cycle's parity; the following cycle is
            // even (a read slot) exactly when the current one is odd.
            DUMMY: begin
               if (par_reg) begin
                  state_reg <= READ;
                  rd_reg    <= 1'b1;
                  addr_reg  <= {page_reg, 8'(idx_reg)};
               end else begin
                  state_reg <= ALIGN;
               end
            end

            ALIGN: begin
               state_reg <= READ;
               rd_reg    <= 1'b1;
               addr_reg  <= {page_reg, 8'(idx_reg)};
            end

            READ: begin
               state_reg <= WRITE;
               cs_n_reg  <= 1'b0;
               we_reg    <= 1'b1;
            end

            WRITE: begin
               idx_reg <= idx_inc;
               if (idx_reg == IDX_LAST) begin
                  state_reg <= IDLE;
                  halt_reg  <= 1'b0;
                  busy_reg  <= 1'b0;
               end else begin
                  state_reg <= READ;
                  rd_reg    <= 1'b1;
                  addr_reg  <= {page_reg, 8'(idx_inc)};
               end
            end

            default: begin
               state_reg <= IDLE;
               halt_reg  <= 1'b0;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.cpu_halt     = halt_reg;
   assign bus.dma_rd       = rd_reg;
   assign bus.dma_addr     = addr_reg;
   assign bus.ppu_cs_n     = cs_n_reg;
   assign bus.ppu_we       = we_reg;
   assign bus.busy         = busy_reg;
   assign bus.ppu_reg_addr = OAMDATA_IDX;

   // The synchronous RAM returns the byte during the WRITE cycle itself, so
   // the data is forwarded straight through; it is gated by the registered
   // write enable so the bus reads zero whenever no write is in progress.
   assign bus.ppu_wdata = we_reg ? bus.dma_rdata : 8'h00;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// ----------------------------------------------------------------------------
// tb_oam_dma_ctrl
// Scoreboard bench for oam_dma_ctrl. Each trigger pushes the expected read
// addresses, PPU write bytes and halt length into queues; a monitor pops and
// compares whenever the DUT strobes dma_rd, ppu_we or ends a halt window.
// ----------------------------------------------------------------------------
module tb_oam_dma_ctrl;

   logic clk = 1'b0;
   logic reset = 1'b0;

   oam_dma_ctrl_if bus ();

   oam_dma_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;

   // Reference memory and bench-side parity (edges since reset release).
   logic [7:0]  mem [0:65535];
   int          cyc;
   logic [15:0] rd_q [$];
   logic [7:0]  wr_q [$];
   int          len_q [$];
   int          n_checks = 0;
   int          n_fail = 0;
   int          wr_seen = 0;

   always @(posedge clk or posedge reset) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   // Synchronous-read CPU memory map.
   always @(posedge clk) begin
      if (bus.dma_rd) bus.dma_rdata <= mem[bus.dma_addr];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: compares every DUT output event against the scoreboard.
   initial begin : monitor
      int run;
      run = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            run = 0;
         end else begin
            if (bus.dma_rd) begin
               check("rd_parity_even", 32'(cyc % 2), 32'd0);
               if (rd_q.size() == 0) check("unexpected_rd", {16'h0, bus.dma_addr}, 32'hFFFF_FFFF);
               else check("dma_addr", {16'h0, bus.dma_addr}, {16'h0, rd_q.pop_front()});
            end
            if (bus.ppu_we) begin
               wr_seen++;
               check("wr_parity_odd", 32'(cyc % 2), 32'd1);
               check("ppu_cs_n", {31'h0, bus.ppu_cs_n}, 32'd0);
               check("ppu_reg_addr", {29'h0, bus.ppu_reg_addr}, 32'd4);
               if (wr_q.size() == 0) check("unexpected_wr", {24'h0, bus.ppu_wdata}, 32'hFFFF_FFFF);
               else check("ppu_wdata", {24'h0, bus.ppu_wdata}, {24'h0, wr_q.pop_front()});
            end
            if (bus.cpu_halt) begin
               run++;
               check("busy_with_halt", {31'h0, bus.busy}, 32'd1);
            end else if (run > 0) begin
               if (len_q.size() == 0) check("unexpected_halt", 32'(run), 32'd0);
               else check("halt_len", 32'(run), 32'(len_q.pop_front()));
               run = 0;
            end
         end
      end
   end

   // Issue a trigger write whose edge falls on a cycle of parity want_par.
   task automatic do_trigger(input logic [7:0] p, input int want_par);
      @(negedge clk);
      while ((cyc % 2) != want_par) @(negedge clk);
      for (int i = 0; i < 256; i++) begin
         rd_q.push_back({p, 8'(i)});
         wr_q.push_back(mem[{p, 8'(i)}]);
      end
      // HALT + DUMMY + 256 read/write pairs, plus ALIGN when DUMMY would
      // otherwise be followed by an odd cycle.
      len_q.push_back((want_par == 1) ? 514 : 515);
      bus.cpu_addr  = 16'h4014;
      bus.cpu_we    = 1'b1;
      bus.cpu_wdata = p;
      @(negedge clk);
      bus.cpu_we   = 1'b0;
      bus.cpu_addr = 16'h8000 | 16'($urandom_range(0, 16'h7FFF));
      check("busy_after_trigger", {31'h0, bus.busy}, 32'd1);
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while (bus.busy && n < 700) begin
         @(negedge clk);
         n++;
      end
      check({name, "_timeout"}, {31'h0, bus.busy}, 32'd0);
      #1;
      check({name, "_rd_left"}, 32'(rd_q.size()), 32'd0);
      check({name, "_wr_left"}, 32'(wr_q.size()), 32'd0);
      check({name, "_len_left"}, 32'(len_q.size()), 32'd0);
      check({name, "_halt_idle"}, {31'h0, bus.cpu_halt}, 32'd0);
   endtask

   initial begin : driver
      int n;
      int base;
      logic [7:0] pg;

      bus.cpu_addr  = 16'h0000;
      bus.cpu_we    = 1'b0;
      bus.cpu_wdata = 8'h00;
      for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
      for (int i = 0; i < 256; i++) mem[16'h0200 + i] = ~8'(i);

      // Reset state
      #1 reset = 1'b1;
      #1;
      check("rst_cpu_halt", {31'h0, bus.cpu_halt}, 32'd0);
      check("rst_ppu_cs_n", {31'h0, bus.ppu_cs_n}, 32'd1);
      check("rst_ppu_we", {31'h0, bus.ppu_we}, 32'd0);
      check("rst_dma_rd", {31'h0, bus.dma_rd}, 32'd0);
      check("rst_busy", {31'h0, bus.busy}, 32'd0);
      check("rst_dma_addr", {16'h0, bus.dma_addr}, 32'd0);
      check("rst_ppu_wdata", {24'h0, bus.ppu_wdata}, 32'd0);
      check("rst_ppu_reg_addr", {29'h0, bus.ppu_reg_addr}, 32'd4);
      #10 reset = 1'b0;
      $display("reset released");

      // Page 02, trigger edge on par=1 -> 514 halted cycles
      do_trigger(8'h02, 1);
      wait_done("xfer_p02_odd");
      $display("transfer page 02 (odd edge) done");

      // Same page, edge on par=0 -> ALIGN inserted, 515 cycles
      repeat ($urandom_range(1, 5)) @(negedge clk);
      do_trigger(8'h02, 0);
      wait_done("xfer_p02_even");
      $display("transfer page 02 (even edge) done");

      // Trigger to page 05 mid-transfer must be ignored
      do_trigger(8'h02, int'($urandom_range(0, 1)));
      repeat ($urandom_range(10, 400)) @(negedge clk);
      bus.cpu_addr  = 16'h4014;
      bus.cpu_we    = 1'b1;
      bus.cpu_wdata = 8'h05;
      @(negedge clk);
      bus.cpu_we = 1'b0;
      wait_done("xfer_ignore_retrigger");
      $display("transfer with ignored retrigger done");

      // Reset at byte 100, then a full transfer from page 03
      base = wr_seen;
      do_trigger(8'h03, int'($urandom_range(0, 1)));
      n = 0;
      do begin
         @(negedge clk);
         #1;
         n++;
      end while (!(wr_seen == base + 101 && bus.ppu_we) && n < 400);
      check("reach_byte100", 32'(wr_seen - base), 32'd101);
      #1 reset = 1'b1;
      #1;
      check("midrst_cpu_halt", {31'h0, bus.cpu_halt}, 32'd0);
      check("midrst_ppu_we", {31'h0, bus.ppu_we}, 32'd0);
      check("midrst_dma_rd", {31'h0, bus.dma_rd}, 32'd0);
      check("midrst_busy", {31'h0, bus.busy}, 32'd0);
      rd_q.delete();
      wr_q.delete();
      len_q.delete();
      @(negedge clk);
      #2 reset = 1'b0;
      $display("reset applied mid-transfer at byte 100");
      do_trigger(8'h03, int'($urandom_range(0, 1)));
      wait_done("xfer_p03_after_rst");
      $display("transfer page 03 after reset done");

      // Non-trigger accesses: write to $4015, read of $4014
      @(negedge clk);
      bus.cpu_addr  = 16'h4015;
      bus.cpu_we    = 1'b1;
      bus.cpu_wdata = 8'h07;
      @(negedge clk);
      bus.cpu_addr  = 16'h4014;
      bus.cpu_we    = 1'b0;
      bus.cpu_wdata = 8'h09;
      @(negedge clk);
      bus.cpu_addr = 16'h0000;
      repeat (8) begin
         @(negedge clk);
         check("no_trigger_busy", {31'h0, bus.busy}, 32'd0);
      end
      $display("non-trigger accesses ignored");

      // Random pages with random edge parity
      for (int t = 0; t < 3; t++) begin
         pg = 8'($urandom);
         repeat ($urandom_range(1, 6)) @(negedge clk);
         do_trigger(pg, int'($urandom_range(0, 1)));
         wait_done("xfer_random");
         $display("random transfer page %02h done", pg);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
